// File: rtl/pll_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reconfig_ctrl
//
// Sequences a runtime frequency change of the system PLL through the PLL
// reconfiguration management bus. On an accepted request it latches the new
// M/C0/C1 counter words and issues the mode, M, C0, C1 and start writes. It then
// waits for a stable lock. The dependent clock domain is held in reset for the
// whole sequence.
//
// Ports:
//   clk, reset_n        management clock, asynchronous active-low reset
//   req                 single-cycle pulse; only accepted in IDLE
//   m_cfg/c0_cfg/c1_cfg 18-bit counter words {odd, bypass, hi[7:0], lo[7:0]}
//   mgmt_*              reconfig management bus (write-only, waitrequest mode)
//   pll_locked          asynchronous PLL lock indication
//   busy                high from request acceptance until DONE/ERR
//   done                one-cycle pulse on successful completion
//   error               sticky lock-timeout flag, cleared by the next request
//   clk_rst_n           active-low reset to the PLL-output clock domain
// -----------------------------------------------------------------------------
module pll_reconfig_ctrl #(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 16,
  parameter int TO_W         = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [17:0] m_cfg,
  input  logic [17:0] c0_cfg,
  input  logic [17:0] c1_cfg,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        clk_rst_n
);

  localparam int ST_W = $clog2(LOCK_STABLE + 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_WR_MODE, S_WR_M, S_WR_C0, S_WR_C1,
    S_WR_START, S_WAIT_LOCK, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             gap_q, gap_d;          // one idle bus cycle after each write
  logic             lock_meta, lock_sync;
  logic [ST_W-1:0]  stable_q, stable_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [17:0]      m_lat, c0_lat, c1_lat;
  logic             error_q, clk_rst_q;
  logic             accept, release_clk, set_error;
  logic             stable_hit, timeout_hit;
  logic             wr_state;
  logic [5:0]       wr_addr;
  logic [31:0]      wr_data;
  state_t           wr_next;

  // The current cycle is the LOCK_STABLE-th consecutive high sample.
  assign stable_hit  = lock_sync && (stable_q == ST_W'(LOCK_STABLE - 1));
  assign timeout_hit = (to_q == TO_W'(LOCK_TIMEOUT - 1));

  assign mgmt_read = 1'b0;
  assign error     = error_q;
  assign clk_rst_n = clk_rst_q;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage shift; a
      // blocking '=' would collapse both flops into one.
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default here so that no path
    // through the case statement leaves a value unassigned and infers a latch.
    state_d        = state_q;
    gap_d          = gap_q;
    stable_d       = '0;
    to_d           = '0;
    accept         = 1'b0;
    release_clk    = 1'b0;
    set_error      = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    busy           = 1'b0;
    done           = 1'b0;
    wr_state       = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    wr_next        = state_q;

    case (state_q)
      S_INIT: begin
        stable_d = lock_sync ? stable_q + 1'b1 : '0;
        if (stable_hit) begin
          state_d     = S_IDLE;
          release_clk = 1'b1;
        end
      end
      S_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = S_WR_MODE;
          gap_d   = 1'b0;
        end
      end
      S_WR_MODE: begin
        wr_state = 1'b1;                   // addr 0, data 0: waitrequest mode
        wr_next  = S_WR_M;
      end
      S_WR_M: begin
        wr_state = 1'b1;
        wr_addr  = 6'd4;
        wr_data  = {14'b0, m_lat};
        wr_next  = S_WR_C0;
      end
      S_WR_C0: begin
        wr_state = 1'b1;
        wr_addr  = 6'd5;
        wr_data  = {9'b0, 5'd0, c0_lat};   // counter index in [22:18]
        wr_next  = S_WR_C1;
      end
      S_WR_C1: begin
        wr_state = 1'b1;
        wr_addr  = 6'd5;
        wr_data  = {9'b0, 5'd1, c1_lat};
        wr_next  = S_WR_START;
      end
      S_WR_START: begin
        wr_state = 1'b1;
        wr_addr  = 6'd2;
        wr_data  = 32'd1;
        wr_next  = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        busy     = 1'b1;
        stable_d = lock_sync ? stable_q + 1'b1 : '0;
        to_d     = to_q + 1'b1;
        // A stable lock on the timeout cycle still counts as success.
        if (stable_hit) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d   = S_ERR;
          set_error = 1'b1;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        release_clk = 1'b1;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // Shared write handshake: hold the command until waitrequest drops, then
    // spend one cycle with the strobe low before the next write.
    if (wr_state) begin
      busy = 1'b1;
      if (gap_q) begin
        gap_d = 1'b0;
      end else begin
        mgmt_write     = 1'b1;
        mgmt_address   = wr_addr;
        mgmt_writedata = wr_data;
        if (!mgmt_waitrequest) begin
          state_d = wr_next;
          gap_d   = (wr_next != S_WAIT_LOCK);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      gap_q     <= 1'b0;
      stable_q  <= '0;
      to_q      <= '0;
      error_q   <= 1'b0;
      clk_rst_q <= 1'b0;
      // NOTE: the configuration latches are reset too; they are only a few
      // flops and a known value keeps the bus data deterministic after reset.
      m_lat     <= '0;
      c0_lat    <= '0;
      c1_lat    <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      stable_q <= stable_d;
      to_q     <= to_d;
      if (accept) begin
        m_lat   <= m_cfg;
        c0_lat  <= c0_cfg;
        c1_lat  <= c1_cfg;
        error_q <= 1'b0;
      end else if (set_error) begin
        error_q <= 1'b1;
      end
      if (accept) begin
        clk_rst_q <= 1'b0;
      end else if (release_clk) begin
        clk_rst_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequences a runtime frequency change of the system PLL (Cyclone V, reconfigurable subtype) through the PLL reconfiguration management bus.
- On request, latches new M, C0 and C1 counter settings and performs the mode, M, C0, C1 and start writes.
- Then waits for PLL lock and holds the dependent clock domain in reset throughout.
- Sits between the core's clock-select logic (turbo/normal CPU clock) and the PLL reconfig block.

Parameters:
LOCK_TIMEOUT, 65535, max clk cycles to wait for locked after start write before flagging error
LOCK_STABLE, 16, consecutive cycles locked must be high before completion
TO_W, 16, width of timeout counter (must hold LOCK_TIMEOUT)

Ports:
clk  in  1  management clock (PLL refclk domain, 50 MHz)
reset_n  in  1  asynchronous active-low reset
req  in  1  single-cycle pulse: start reconfiguration
m_cfg  in  18  M counter word: [17] odd-duty, [16] bypass, [15:8] hi, [7:0] lo
c0_cfg  in  18  C0 counter word, same format
c1_cfg  in  18  C1 counter word, same format
mgmt_address  out  6  reconfig register address
mgmt_write  out  1  write strobe
mgmt_read  out  1  read strobe (tied 0)
mgmt_writedata  out  32  write data
mgmt_waitrequest  in  1  reconfig block stall
pll_locked  in  1  PLL locked (asynchronous; double-flopped internally)
busy  out  1  high from req acceptance until DONE/ERR
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky lock-timeout flag; cleared by next accepted req
clk_rst_n  out  1  active-low reset to PLL-output clock domain

Behaviour:
- Reset values: mgmt_address=0, mgmt_write=0, mgmt_read=0, mgmt_writedata=0, busy=0, done=0, error=0, clk_rst_n=0.
- After reset, clk_rst_n rises once synchronized pll_locked has been high LOCK_STABLE cycles (state INIT).
- States:
  - INIT -> IDLE after stable lock.
  - IDLE -> WR_MODE -> WR_M -> WR_C0 -> WR_C1 -> WR_START -> WAIT_LOCK -> DONE (1 cycle) -> IDLE.
  - WAIT_LOCK -> ERR (1 cycle) -> IDLE on timeout.
- req accepted only in IDLE. On the accept cycle:
  - latch m_cfg/c0_cfg/c1_cfg.
  - busy=1 and clk_rst_n=0 from the next cycle.
  - clear error.
- req in any other state is ignored; no queuing.
- Writes, in order:
  - WR_MODE: addr 0, data 0 (waitrequest mode).
  - WR_M: addr 4, data {14'b0, m_lat}.
  - WR_C0: addr 5, data {9'b0, 5'd0, c0_lat}, counter index at bits [22:18].
  - WR_C1: addr 5, data {9'b0, 5'd1, c1_lat}.
  - WR_START: addr 2, data 1.
- Write handshake:
  - In each WR_* state, mgmt_write=1 with address/data stable.
  - Write completes on the first rising edge where mgmt_waitrequest=0.
  - Next cycle: mgmt_write=0 for exactly one idle cycle, then the next WR_* state asserts.
  - Minimum 2 cycles per write. Waitrequest may stay high indefinitely; no bus timeout.
- WAIT_LOCK:
  - Timeout counter clears on entry and increments every cycle.
  - Stable counter increments while sync locked=1 and clears to 0 when locked=0.
  - Stable reaches LOCK_STABLE -> DONE.
  - Timeout reaches LOCK_TIMEOUT first -> ERR.
  - Both on the same cycle -> DONE wins.
  - A lock glitch low restarts the stable count but not the timeout.
- DONE: done=1 for 1 cycle, busy=0 and clk_rst_n=1 from the next cycle.
- ERR: error=1 (sticky), busy=0, clk_rst_n stays 0. The parent must re-request.
- Async reset at any point returns to INIT with all outputs at reset values; a partially written configuration is not restored.
- mgmt_read is permanently 0.

Test Plan:
- Reset release, pll_locked high from cycle 3 -> clk_rst_n=1 after 2-cycle sync + 16 cycles; busy=0, error=0.
- req with m_cfg=18'h00303, c0=18'h20201, c1=18'h00303, waitrequest always 0 -> five writes, each 1 cycle with a 1-cycle gap:
  - addr0/0x0, addr4/0x303, addr5/0x20201, addr5/0x40303, addr2/0x1.
  - locked high -> done pulse, clk_rst_n=1.
- waitrequest held high 5 cycles during the WR_M write -> address/data/mgmt_write stable all 5 cycles; sequence continues unchanged.
- pll_locked never returns, LOCK_TIMEOUT=100 -> ERR after 100 WAIT_LOCK cycles; error=1 sticky, clk_rst_n=0, busy=0.
  - Next req clears error.
- Lock goes high for 10 cycles, drops for 1 cycle, then stays high -> done only after 16 consecutive high cycles.
- req pulses while busy ignored; reset_n asserted mid-WR_C0 -> all outputs immediately at reset values, FSM restarts in INIT.
